tlc_light_sequencer: RTL and testbench
======================================

Name: tlc_light_sequencer

Overview:
Lamp-phase sequencer for the intersection: the per-lamp slave of the traffic-light master FSM. It takes the master's requested right-of-way direction and drives the NS, EW and left-turn lamp heads through a safe GREEN -> YELLOW -> ALL-RED -> GREEN sequence. It returns `ok` to the master when the current green has served its minimum time and matches the request. It owns its own phase counters, so the master only decides *which* direction gets right-of-way.

Parameters:
- CW, 4, phase-counter width; each timing parameter must be in the range 1 .. 2^CW.
- MIN_GREEN, 4, minimum cycles a direction stays GREEN before it may be released.
- YELLOW_T, 3, cycles spent in YELLOW.
- ALLRED_T, 2, cycles spent in ALL-RED.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- dir  input  2  requested direction from master: 00 = NS, 01 = EW, 10 = LT, 11 = invalid
- ok  output  1  current green is releasable and matches dir
- ns_lamp  output  3  NS head {red, yellow, green}
- ew_lamp  output  3  EW head {red, yellow, green}
- lt_lamp  output  3  LT head {red, yellow, green}
- phase  output  2  debug: 00 = GREEN, 01 = YELLOW, 10 = ALLRED

Behaviour:
- Registered state: phase register, cur[1:0] (direction being served), cnt[CW-1:0].
- Reset (rst=1 at a posedge):
  - phase = GREEN, cur = NS, cnt = MIN_GREEN-1.
  - Outputs: ns_lamp = 001, ew_lamp = 100, lt_lamp = 100, ok = 0.
- Reset asserted mid-sequence (any phase) forces the reset state on the next edge. There is no yellow/all-red on reset.
- Counter rules:
  - On entry to a phase, cnt is loaded with that phase's T-1.
  - cnt decrements each cycle while nonzero and holds at 0.
  - A phase may exit only when cnt == 0.
  - Resulting phase lengths: GREEN is at least MIN_GREEN cycles; YELLOW is exactly YELLOW_T; ALLRED is at least ALLRED_T.
- GREEN:
  - If cnt == 0 and dir != cur, the next phase is YELLOW and cnt = YELLOW_T-1.
  - Otherwise stay in GREEN. A dir change before the minimum green is served is held off until cnt reaches 0.
- YELLOW: when cnt == 0, go to ALLRED and set cnt = ALLRED_T-1. Once YELLOW is entered the sequence is committed; dir changes do not abort it, including dir returning to cur.
- ALLRED:
  - When cnt == 0 and dir != 11: cur = dir, go to GREEN, cnt = MIN_GREEN-1.
  - If dir == cur (a request that flipped back), the same direction still gets a fresh green.
  - If dir == 11: hold ALLRED indefinitely (fail-safe) until a valid dir arrives.
- GREEN with dir == 11 behaves like a change request: after the minimum green, the block sequences to ALLRED and holds there.
- Lamp decode (combinational from registered phase/cur only, no input dependence):
  - GREEN: cur head = 001, others = 100.
  - YELLOW: cur head = 010, others = 100.
  - ALLRED: all heads = 100.
  - No two heads are ever non-red simultaneously. No head ever goes green -> red without passing through yellow, except on reset.
- ok = (phase == GREEN) && (cnt == 0) && (dir == cur).
  - Combinational in dir. The master's dir is a registered output, so no loop is formed.
  - ok is 0 throughout YELLOW and ALLRED.
- phase = 11 is unreachable. If it is ever entered, the next state is ALLRED with cnt = ALLRED_T-1, and all lamps read 100.

Test Plan:
1. Reset release with dir=00: ns_lamp=001 and the others 100 from the first cycle; ok=0 for 3 cycles and ok=1 from the 4th GREEN cycle onward; lamps are stable while dir stays 00.
2. After ok=1, set dir=01 → next cycle ns_lamp=010 for exactly 3 cycles, then all 100 for 2 cycles, then ew_lamp=001 with ok=0 for 3 cycles, then ok=1.
3. Set dir=10 on the 2nd cycle of an NS green → GREEN holds until the 4th cycle, then YELLOW(3) and ALLRED(2), then lt_lamp=001; ok stays 0 throughout, never 1 in the NS green.
4. During EW YELLOW, switch dir back to 01 → YELLOW(3) and ALLRED(2) still occur, then ew_lamp=001 with a fresh 4-cycle minimum green.
5. dir=11 during GREEN after the minimum → YELLOW(3), then all lamps 100 held for 20+ cycles with ok=0; set dir=00 → the next cycle (cnt already 0) phase=GREEN and ns_lamp=001.
6. Assert rst during YELLOW and during ALLRED → the next cycle is phase=00, ns_lamp=001, cnt restarts, ok=0. A bench assertion checks every cycle that at most one head has red=0.

Source files
------------

// File: rtl/tlc_light_sequencer.sv
// tlc_light_sequencer: lamp-phase slave of the intersection master FSM.
// The master's registered dir picks which direction should have right-of-way.
// This block walks the lamps through GREEN -> YELLOW -> ALLRED -> GREEN on its own timers.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   dir[1:0]    requested direction (00 NS, 01 EW, 10 LT, 11 invalid -> hold all-red)
//   ok          current green has met its minimum time and matches dir (combinational in dir)
//   ns/ew/lt_lamp[2:0]  {red, yellow, green} per head, registered
//   phase[1:0]  debug view of the phase register (00 GREEN, 01 YELLOW, 10 ALLRED)
// Each timing parameter must lie in 1 .. 2**CW.

module tlc_light_sequencer #(
  parameter int CW        = 4,
  parameter int MIN_GREEN = 4,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
  output logic       ok,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [2:0] lt_lamp,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_BAD    = 2'b11
  } phase_e;

  localparam logic [1:0] DIR_NS  = 2'b00;
  localparam logic [1:0] DIR_EW  = 2'b01;
  localparam logic [1:0] DIR_LT  = 2'b10;
  localparam logic [1:0] DIR_INV = 2'b11;

  // Counters load T-1 on phase entry so that a phase lasts T cycles down to 0.
  localparam logic [CW-1:0] GREEN_LD  = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_T - 1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  phase_e        phase_q, phase_d;
  logic [1:0]    cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;
  logic [2:0]    lt_q, lt_d;
  logic [2:0]    head_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next-state: counter saturates at 0; a phase only exits once it reaches 0.
  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    cnt_d   = cnt_zero ? cnt_q : (cnt_q - 1'b1);
    case (phase_q)
      PH_GREEN: begin
        // An invalid dir also counts as a change request and ends up parked in ALLRED.
        if (cnt_zero && (dir != cur_q)) begin
          phase_d = PH_YELLOW;
          cnt_d   = YELLOW_LD;
        end
      end
      PH_YELLOW: begin
        // Committed: dir is ignored here, even if it flips back to cur.
        if (cnt_zero) begin
          phase_d = PH_ALLRED;
          cnt_d   = ALLRED_LD;
        end
      end
      PH_ALLRED: begin
        // dir == cur still gets a fresh full green; dir == 11 holds all-red.
        if (cnt_zero && (dir != DIR_INV)) begin
          phase_d = PH_GREEN;
          cur_d   = dir;
          cnt_d   = GREEN_LD;
        end
      end
      default: begin
        // Unreachable encoding: recover through a full all-red interval.
        phase_d = PH_ALLRED;
        cnt_d   = ALLRED_LD;
      end
    endcase
  end

  // Lamp decode from the next state so the lamp registers track phase/cur exactly.
  always_comb begin
    ns_d = LAMP_RED;
    ew_d = LAMP_RED;
    lt_d = LAMP_RED;
    case (phase_d)
      PH_GREEN:  head_d = LAMP_GRN;
      PH_YELLOW: head_d = LAMP_YEL;
      default:   head_d = LAMP_RED;
    endcase
    case (cur_d)
      DIR_NS:  ns_d = head_d;
      DIR_EW:  ew_d = head_d;
      DIR_LT:  lt_d = head_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset drops straight to NS green; no yellow/all-red transition.
      phase_q <= PH_GREEN;
      cur_q   <= DIR_NS;
      cnt_q   <= GREEN_LD;
      ns_q    <= LAMP_GRN;
      ew_q    <= LAMP_RED;
      lt_q    <= LAMP_RED;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      lt_q    <= lt_d;
    end
  end

  assign ok      = (phase_q == PH_GREEN) && cnt_zero && (dir == cur_q);
  assign ns_lamp = ns_q;
  assign ew_lamp = ew_q;
  assign lt_lamp = lt_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_tlc_light_sequencer.sv
// Directed bench for tlc_light_sequencer with default parameters
// (MIN_GREEN=4, YELLOW_T=3, ALLRED_T=2). Each cycle compares the word
// {phase, ns_lamp, ew_lamp, lt_lamp, ok} against hand-written constants.

module tb_tlc_light_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dir = 2'b00;
  logic       ok;
  logic [2:0] ns_lamp, ew_lamp, lt_lamp;
  logic [1:0] phase;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // {phase, ns, ew, lt, ok}
  localparam logic [11:0] NS_G  = 12'b00_001_100_100_0;
  localparam logic [11:0] NS_GK = 12'b00_001_100_100_1;
  localparam logic [11:0] NS_Y  = 12'b01_010_100_100_0;
  localparam logic [11:0] EW_G  = 12'b00_100_001_100_0;
  localparam logic [11:0] EW_GK = 12'b00_100_001_100_1;
  localparam logic [11:0] EW_Y  = 12'b01_100_010_100_0;
  localparam logic [11:0] LT_G  = 12'b00_100_100_001_0;
  localparam logic [11:0] LT_GK = 12'b00_100_100_001_1;
  localparam logic [11:0] LT_Y  = 12'b01_100_100_010_0;
  localparam logic [11:0] ALLR  = 12'b10_100_100_100_0;

  tlc_light_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .dir     (dir),
    .ok      (ok),
    .ns_lamp (ns_lamp),
    .ew_lamp (ew_lamp),
    .lt_lamp (lt_lamp),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  assign obs = {phase, ns_lamp, ew_lamp, lt_lamp, ok};

  // At most one head may show a non-red aspect in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((int'(!ns_lamp[2]) + int'(!ew_lamp[2]) + int'(!lt_lamp[2])) > 1) begin
        errors++;
        $display("FAIL heads_exclusive t=%0t: ns=%b ew=%b lt=%b, required at most one red=0",
                 $time, ns_lamp, ew_lamp, lt_lamp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp [5] = '{NS_G, NS_G, NS_GK, NS_GK, NS_GK};
    rst = 1'b1;
    dir = 2'b00;
    tick();
    tick();
    mon_en = 1'b1;
    checks++;
    if (obs !== NS_G) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs, NS_G);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_ns_to_ew();
    logic [11:0] exp [10] = '{NS_Y, NS_Y, NS_Y, ALLR, ALLR,
                              EW_G, EW_G, EW_G, EW_GK, EW_GK};
    dir = 2'b01;
    #1;
    checks++;
    if (ok !== 1'b0) begin
      errors++;
      $display("FAIL ok_follows_dir: got %b want 0", ok);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL ns_to_ew cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_min_green_holdoff();
    logic [11:0] exp [11] = '{NS_G, NS_G, NS_Y, NS_Y, NS_Y, ALLR, ALLR,
                              LT_G, LT_G, LT_G, LT_GK};
    rst = 1'b1;
    dir = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== NS_G) begin
      errors++;
      $display("FAIL holdoff_green2: got %b want %b", obs, NS_G);
    end
    dir = 2'b10;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL min_green_holdoff cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_yellow_commit();
    logic [11:0] pre [9] = '{LT_Y, LT_Y, LT_Y, ALLR, ALLR, EW_G, EW_G, EW_G, EW_GK};
    logic [11:0] exp [8] = '{EW_Y, EW_Y, ALLR, ALLR, EW_G, EW_G, EW_G, EW_GK};
    dir = 2'b01;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (obs !== pre[i]) begin
        errors++;
        $display("FAIL lt_to_ew cyc %0d: got %b want %b", i, obs, pre[i]);
      end
    end
    dir = 2'b00;
    tick();
    checks++;
    if (obs !== EW_Y) begin
      errors++;
      $display("FAIL ew_yellow_entry: got %b want %b", obs, EW_Y);
    end
    dir = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL yellow_commit cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_invalid_dir();
    logic [11:0] exp [4] = '{NS_G, NS_G, NS_G, NS_GK};
    logic [11:0] want;
    dir = 2'b11;
    for (int i = 0; i < 25; i++) begin
      tick();
      want = (i < 3) ? EW_Y : ALLR;
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL invalid_dir_hold cyc %0d: got %b want %b", i, obs, want);
      end
    end
    dir = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL invalid_recover cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp [3] = '{NS_G, NS_G, NS_GK};
    // Reset during YELLOW.
    dir = 2'b01;
    tick();
    tick();
    checks++;
    if (obs !== NS_Y) begin
      errors++;
      $display("FAIL pre_reset_yellow: got %b want %b", obs, NS_Y);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== NS_G) begin
      errors++;
      $display("FAIL reset_in_yellow: got %b want %b", obs, NS_G);
    end
    rst = 1'b0;
    dir = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL after_yellow_reset cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
    // Reset during ALLRED.
    dir = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (obs !== ALLR) begin
      errors++;
      $display("FAIL pre_reset_allred: got %b want %b", obs, ALLR);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs !== NS_G) begin
      errors++;
      $display("FAIL reset_in_allred: got %b want %b", obs, NS_G);
    end
    rst = 1'b0;
    dir = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL after_allred_reset cyc %0d: got %b want %b", i, obs, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ns_to_ew();
    test_min_green_holdoff();
    test_yellow_commit();
    test_invalid_dir();
    test_reset_mid();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
